// File: rtl/cpe_config_master_if.sv
// AXI-Lite write-only bus between the CPE configuration master and its slave.
interface cpe_config_master_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [31:0]           m_axi_wdata;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid
  );
endinterface

// File: rtl/cpe_config_master.sv
// AXI-Lite write initiator that walks a fixed register list to configure a CPE
// controller: reset, enable, image size, then the filter coefficients.
module cpe_config_master #(
  parameter int ADDR_WIDTH  = 10,
  parameter int KERNEL_SIZE = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                                    axi_clk,
  input  logic                                    axi_reset,
  input  logic                                    start,
  input  logic [15:0]                             cfg_width,
  input  logic [15:0]                             cfg_height,
  input  logic [32*KERNEL_SIZE*KERNEL_SIZE-1:0]   cfg_coef,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    error,
  cpe_config_master_if.master                     axi
);
  localparam int NCOEF = KERNEL_SIZE * KERNEL_SIZE;
  localparam int N     = 4 + NCOEF;
  localparam int IDX_W = $clog2(N);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RESP, S_DONE, S_ERR} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [TMR_W-1:0]       timer;
  logic [15:0]            width_q;
  logic [15:0]            height_q;
  logic [32*NCOEF-1:0]    coef_q;
  logic                   aw_ok;
  logic                   w_ok;

  assign idx_nxt = idx + 1'b1;
  // A channel is finished once its valid has dropped or is handshaking now.
  assign aw_ok = ~axi.m_axi_awvalid | axi.m_axi_awready;
  assign w_ok  = ~axi.m_axi_wvalid  | axi.m_axi_wready;

  function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [IDX_W-1:0] k);
    case (k)
      IDX_W'(0): return ADDR_WIDTH'(4);
      IDX_W'(1): return ADDR_WIDTH'(0);
      IDX_W'(2): return ADDR_WIDTH'(16);
      IDX_W'(3): return ADDR_WIDTH'(20);
      default:   return ADDR_WIDTH'(32'd24 + 32'd4 * (32'(k) - 32'd4));
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [IDX_W-1:0] k);
    case (k)
      IDX_W'(0), IDX_W'(1): return 32'd1;
      IDX_W'(2):            return {16'd0, width_q};
      IDX_W'(3):            return {16'd0, height_q};
      default:              return coef_q[32 * (32'(k) - 32'd4) +: 32];
    endcase
  endfunction

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state             <= S_IDLE;
      idx               <= '0;
      timer             <= '0;
      width_q           <= '0;
      height_q          <= '0;
      coef_q            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      axi.m_axi_awaddr  <= '0;
      axi.m_axi_awvalid <= 1'b0;
      axi.m_axi_wdata   <= '0;
      axi.m_axi_wvalid  <= 1'b0;
      axi.m_axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            width_q           <= cfg_width;
            height_q          <= cfg_height;
            coef_q            <= cfg_coef;
            idx               <= '0;
            timer             <= '0;
            axi.m_axi_awaddr  <= wr_addr('0);
            axi.m_axi_wdata   <= 32'd1;
            axi.m_axi_awvalid <= 1'b1;
            axi.m_axi_wvalid  <= 1'b1;
            busy              <= 1'b1;
            error             <= 1'b0;
            state             <= S_ADDR;
          end
        end
        S_ADDR: begin
          timer <= timer + 1'b1;
          if (axi.m_axi_awvalid && axi.m_axi_awready) axi.m_axi_awvalid <= 1'b0;
          if (axi.m_axi_wvalid && axi.m_axi_wready)   axi.m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            axi.m_axi_bready <= 1'b1;
            state            <= S_RESP;
          end
          // Timeout overrides any progress made in the same cycle.
          if (timer == TMO_LAST) begin
            axi.m_axi_awvalid <= 1'b0;
            axi.m_axi_wvalid  <= 1'b0;
            axi.m_axi_bready  <= 1'b0;
            busy              <= 1'b0;
            error             <= 1'b1;
            state             <= S_ERR;
          end
        end
        S_RESP: begin
          timer <= timer + 1'b1;
          if (axi.m_axi_bvalid && axi.m_axi_bready) begin
            axi.m_axi_bready <= 1'b0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx               <= idx_nxt;
              timer             <= '0;
              axi.m_axi_awaddr  <= wr_addr(idx_nxt);
              axi.m_axi_wdata   <= wr_data(idx_nxt);
              axi.m_axi_awvalid <= 1'b1;
              axi.m_axi_wvalid  <= 1'b1;
              state             <= S_ADDR;
            end
          end
          if (timer == TMO_LAST) begin
            axi.m_axi_awvalid <= 1'b0;
            axi.m_axi_wvalid  <= 1'b0;
            axi.m_axi_bready  <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b1;
            state             <= S_ERR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpe_config_master.sv
// Directed bench: table of full configuration runs plus hand-built sequences
// for back-pressure, timeout, restart attempts and mid-run reset.
module tb_cpe_config_master;
  localparam int AW = 10;
  localparam int KS = 3;
  localparam int NW = 4 + KS * KS;

  logic                  axi_clk;
  logic                  axi_reset;
  logic                  start;
  logic [15:0]           cfg_width;
  logic [15:0]           cfg_height;
  logic [32*KS*KS-1:0]   cfg_coef;
  logic                  busy, done, error;

  cpe_config_master_if #(.ADDR_WIDTH(AW)) bif();

  cpe_config_master #(.ADDR_WIDTH(AW), .KERNEL_SIZE(KS), .TIMEOUT(255)) dut (
    .axi_clk    (axi_clk),
    .axi_reset  (axi_reset),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_coef   (cfg_coef),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .axi        (bif)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  // Slave model: B response can be withheld while the last address was 16.
  logic          b_en   = 1'b1;
  logic          b_hold = 1'b0;
  logic [AW-1:0] last_aw = '0;
  logic [31:0]   aw_q[$];
  logic [31:0]   w_q[$];

  always_comb bif.m_axi_bvalid = b_en && !(b_hold && last_aw == AW'(16));

  always @(posedge axi_clk) begin
    if (bif.m_axi_awvalid && bif.m_axi_awready) begin
      aw_q.push_back(32'(bif.m_axi_awaddr));
      last_aw <= bif.m_axi_awaddr;
    end
    if (bif.m_axi_wvalid && bif.m_axi_wready) w_q.push_back(bif.m_axi_wdata);
  end

  typedef struct {
    logic [15:0]         w;
    logic [15:0]         h;
    logic [32*KS*KS-1:0] coef;
    int                  exp_cycles;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    if (k == 0) return 32'd4;
    if (k == 1) return 32'd0;
    if (k == 2) return 32'd16;
    if (k == 3) return 32'd20;
    return 32'(24 + 4 * (k - 4));
  endfunction

  function automatic logic [31:0] exp_data(input vec_t v, input int k);
    if (k <= 1) return 32'd1;
    if (k == 2) return {16'd0, v.w};
    if (k == 3) return {16'd0, v.h};
    return v.coef[32*(k-4) +: 32];
  endfunction

  // Called at a negedge; pulses start, optionally re-pokes start/width at poke_at.
  task automatic run_seq(input int poke_at, output int n, output bit got_done, output bit got_err);
    n = 0; got_done = 0; got_err = 0;
    start = 1'b1;
    while (n < 1000 && !got_done && !got_err) begin
      @(posedge axi_clk); n++;
      @(negedge axi_clk);
      start = 1'b0;
      if (poke_at != 0 && n == poke_at) begin
        cfg_width = 16'd99;
        start     = 1'b1;
      end
      if (done)  got_done = 1;
      if (error) got_err  = 1;
    end
  endtask

  task automatic clear_q();
    aw_q.delete();
    w_q.delete();
  endtask

  initial begin
    int  n;
    bit  gd, ge;
    int  sz;

    vecs[0].w = 16'd8;   vecs[0].h = 16'd8;   vecs[0].coef = '0;
    vecs[0].coef[32*4 +: 32] = 32'd1;          vecs[0].exp_cycles = 27;
    vecs[1].w = 16'd640; vecs[1].h = 16'd480; vecs[1].coef = '0;
    for (int i = 0; i < KS*KS; i++) vecs[1].coef[32*i +: 32] = 32'(i + 1);
    vecs[1].exp_cycles = 27;
    vecs[2].w = 16'hFFFF; vecs[2].h = 16'd1;  vecs[2].coef = '0;
    for (int i = 0; i < KS*KS; i++) vecs[2].coef[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
    vecs[2].exp_cycles = 27;

    axi_reset = 1'b1; start = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_coef = '0;
    bif.m_axi_awready = 1'b1; bif.m_axi_wready = 1'b1;
    repeat (2) @(negedge axi_clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_error", 64'(error), 0);
    chk("rst_awvalid", 64'(bif.m_axi_awvalid), 0);
    chk("rst_wvalid", 64'(bif.m_axi_wvalid), 0);
    chk("rst_bready", 64'(bif.m_axi_bready), 0);
    chk("rst_awaddr", 64'(bif.m_axi_awaddr), 0);
    axi_reset = 1'b0;
    @(negedge axi_clk);

    // Full-speed runs from the vector table
    for (int v = 0; v < 3; v++) begin
      cfg_width = vecs[v].w; cfg_height = vecs[v].h; cfg_coef = vecs[v].coef;
      clear_q();
      run_seq(0, n, gd, ge);
      chk($sformatf("v%0d_done_seen", v), 64'(gd), 1);
      chk($sformatf("v%0d_cycles", v), 64'(n), 64'(vecs[v].exp_cycles));
      @(negedge axi_clk);
      chk($sformatf("v%0d_done_pulse", v), 64'(done), 0);
      chk($sformatf("v%0d_busy_end", v), 64'(busy), 0);
      chk($sformatf("v%0d_nwrites", v), 64'(aw_q.size()), NW);
      chk($sformatf("v%0d_nwdata", v), 64'(w_q.size()), NW);
      for (int k = 0; k < NW; k++) begin
        if (k < aw_q.size()) chk($sformatf("v%0d_addr%0d", v, k), 64'(aw_q[k]), 64'(exp_addr(k)));
        if (k < w_q.size())  chk($sformatf("v%0d_data%0d", v, k), 64'(w_q[k]), 64'(exp_data(vecs[v], k)));
      end
    end

    // AW back-pressure on the first write, W accepted at once
    cfg_width = 16'd8; cfg_height = 16'd8; cfg_coef = vecs[0].coef;
    clear_q();
    bif.m_axi_awready = 1'b0;
    start = 1'b1;
    @(posedge axi_clk); @(negedge axi_clk); start = 1'b0;
    chk("bp_c1_awvalid", 64'(bif.m_axi_awvalid), 1);
    chk("bp_c1_wvalid", 64'(bif.m_axi_wvalid), 1);
    chk("bp_c1_awaddr", 64'(bif.m_axi_awaddr), 4);
    chk("bp_c1_wdata", 64'(bif.m_axi_wdata), 1);
    chk("bp_c1_bready", 64'(bif.m_axi_bready), 0);
    @(posedge axi_clk); @(negedge axi_clk);
    chk("bp_c2_wvalid", 64'(bif.m_axi_wvalid), 0);
    chk("bp_c2_awvalid", 64'(bif.m_axi_awvalid), 1);
    chk("bp_c2_awaddr", 64'(bif.m_axi_awaddr), 4);
    @(posedge axi_clk); @(negedge axi_clk);
    chk("bp_c3_awvalid", 64'(bif.m_axi_awvalid), 1);
    chk("bp_c3_awaddr", 64'(bif.m_axi_awaddr), 4);
    bif.m_axi_awready = 1'b1;
    @(posedge axi_clk); @(negedge axi_clk);
    chk("bp_c4_awvalid", 64'(bif.m_axi_awvalid), 0);
    chk("bp_c4_bready", 64'(bif.m_axi_bready), 1);
    n = 4;
    while (!done && n < 1000) begin
      @(posedge axi_clk); n++; @(negedge axi_clk);
    end
    chk("bp_cycles", 64'(n), 29);
    chk("bp_nwrites", 64'(aw_q.size()), NW);
    if (w_q.size() > 0) chk("bp_first_wdata", 64'(w_q[0]), 1);
    @(negedge axi_clk);

    // Timeout on idx2 response, then recovery
    clear_q();
    b_hold = 1'b1;
    run_seq(0, n, gd, ge);
    chk("to_err_seen", 64'(ge), 1);
    chk("to_no_done", 64'(gd), 0);
    chk("to_busy", 64'(busy), 0);
    chk("to_nwrites", 64'(aw_q.size()), 3);
    chk("to_bready", 64'(bif.m_axi_bready), 0);
    chk("to_awvalid", 64'(bif.m_axi_awvalid), 0);
    b_hold = 1'b0;
    repeat (5) @(negedge axi_clk);
    chk("to_err_sticky", 64'(error), 1);
    chk("to_idle_busy", 64'(busy), 0);
    clear_q();
    run_seq(0, n, gd, ge);
    chk("to_rerun_done", 64'(gd), 1);
    chk("to_rerun_cycles", 64'(n), 27);
    chk("to_rerun_err_clr", 64'(error), 0);
    if (aw_q.size() > 0) chk("to_rerun_first", 64'(aw_q[0]), 4);
    @(negedge axi_clk);

    // Start pulsed mid-run with a new width: no restart, latched width kept
    cfg_width = 16'd8;
    clear_q();
    run_seq(3, n, gd, ge);
    chk("rs_done", 64'(gd), 1);
    chk("rs_cycles", 64'(n), 27);
    chk("rs_nwrites", 64'(aw_q.size()), NW);
    if (aw_q.size() > 2) chk("rs_addr2", 64'(aw_q[2]), 16);
    if (w_q.size() > 2)  chk("rs_width", 64'(w_q[2]), 8);
    start = 1'b0;
    @(negedge axi_clk);
    chk("rs_no_rerun", 64'(busy), 0);

    // Reset during idx5 response phase
    clear_q();
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge axi_clk); @(negedge axi_clk); start = 1'b0;
    end
    chk("mr_bready", 64'(bif.m_axi_bready), 1);
    sz = aw_q.size();
    chk("mr_nwrites", 64'(sz), 6);
    if (sz > 0) chk("mr_last_addr", 64'(aw_q[sz-1]), 28);
    axi_reset = 1'b1;
    #1;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_bready0", 64'(bif.m_axi_bready), 0);
    chk("mr_awvalid", 64'(bif.m_axi_awvalid), 0);
    chk("mr_wvalid", 64'(bif.m_axi_wvalid), 0);
    chk("mr_awaddr", 64'(bif.m_axi_awaddr), 0);
    chk("mr_wdata", 64'(bif.m_axi_wdata), 0);
    chk("mr_error", 64'(error), 0);
    @(negedge axi_clk);
    axi_reset = 1'b0;
    repeat (10) @(negedge axi_clk);
    chk("mr_idle_busy", 64'(busy), 0);
    chk("mr_idle_awvalid", 64'(bif.m_axi_awvalid), 0);
    chk("mr_no_resume", 64'(aw_q.size()), 6);
    clear_q();
    run_seq(0, n, gd, ge);
    chk("mr_new_run", 64'(n), 27);
    if (aw_q.size() > 0) chk("mr_new_first", 64'(aw_q[0]), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
